integration_sequencer: RTL and testbench

Controller that sequences one trapezoidal-rule integration over a window of `num_samples` samples. It is launched by a `start` pulse, pulls samples through a valid/ready handshake, and accumulates `STEP*(prev+cur)` per sample pair, which is `(h+h)*(a+b)*0.5` in integer form. It reports the result with a one-cycle `done` pulse. It sits between the sample source and the consumers of the integral, and replaces free-running integration with a bounded, abortable window.

---
 rtl/integ_pkg.sv | 16 +
 rtl/integration_sequencer_if.sv | 25 ++
 rtl/trap_accum.sv | 50 +++++
 rtl/integration_sequencer.sv | 106 ++++++++++
 tb/tb_integration_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/integ_pkg.sv
// Shared definitions for the integration blocks: sequencer state encoding and
// default datapath sizing.
package integ_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DW   = 64;
    localparam int DEF_CW   = 16;
    localparam int DEF_STEP = 5;

endpackage

// File: rtl/integration_sequencer_if.sv
// Control, sample handshake and result bus of the integration sequencer.
interface integration_sequencer_if #(
    parameter int DW = 64,
    parameter int CW = 16
);
    logic          start;
    logic [CW-1:0] num_samples;
    logic          abort;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          sample_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;

    modport master (
        output start, num_samples, abort, sample_valid, sample_data,
        input  sample_ready, busy, done, result
    );

    modport slave (
        input  start, num_samples, abort, sample_valid, sample_data,
        output sample_ready, busy, done, result
    );
endinterface

// File: rtl/trap_accum.sv
// Trapezoidal accumulator: keeps the previous sample and the running sum of
// STEP*(prev+cur), everything wrapping modulo 2^DW.
module trap_accum
    import integ_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int STEP = DEF_STEP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load_first,
    input  logic          acc_en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] acc_next
);
    localparam logic [DW-1:0] STEP_W = DW'(STEP);

    logic [DW-1:0] prev_q;
    logic [DW-1:0] acc_q;

    // Pair sum and product both wrap; no saturation anywhere in this path.
    function automatic logic [DW-1:0] trap_term(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [DW-1:0] s;
        s = a + b;
        return s * STEP_W;
    endfunction

    always_comb begin
        acc_next = acc_q;
        if (clr)
            acc_next = '0;
        else if (acc_en)
            acc_next = acc_q + trap_term(prev_q, data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            acc_q  <= '0;
        end else begin
            acc_q <= acc_next;
            if (clr)
                prev_q <= '0;
            else if (load_first || acc_en)
                prev_q <= data;
        end
    end
endmodule

// File: rtl/integration_sequencer.sv
// Sequences one bounded, abortable trapezoidal integration window and reports
// the integral with a single-cycle done pulse.
module integration_sequencer
    import integ_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CW   = DEF_CW,
    parameter int STEP = DEF_STEP
) (
    input  logic                    clk,
    input  logic                    resetb,
    integration_sequencer_if.slave  bus
);
    state_t        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [DW-1:0] result_q;
    logic [DW-1:0] acc_next;
    logic          clr, load_first, acc_en;
    logic          in_window;
    logic          accept;

    // Handshake outputs decode from state only, never from sample_valid.
    assign in_window        = (state_q == ST_FIRST) || (state_q == ST_ACCUM);
    assign accept           = bus.sample_valid && in_window && !bus.abort;
    assign cnt_inc          = cnt_q + CW'(1);
    assign bus.sample_ready = in_window;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.result       = result_q;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        clr        = 1'b0;
        load_first = 1'b0;
        acc_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d     = bus.num_samples;
                    cnt_d   = '0;
                    clr     = 1'b1;
                    state_d = (bus.num_samples < CW'(2)) ? ST_DONE : ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    load_first = 1'b1;
                    cnt_d      = CW'(1);
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == n_q)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // DONE always exits after one cycle, so heading into DONE is the entry
    // edge; acc_next already holds the final (or cleared) sum there.
    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            if (state_d == ST_DONE)
                result_q <= acc_next;
        end
    end

    trap_accum #(
        .DW   (DW),
        .STEP (STEP)
    ) u_trap_accum (
        .clk        (clk),
        .rst        (resetb),
        .clr        (clr),
        .load_first (load_first),
        .acc_en     (acc_en),
        .data       (bus.sample_data),
        .acc_next   (acc_next)
    );
endmodule

// File: tb/tb_integration_sequencer.sv
// Directed and randomized checks of the integration sequencer against a
// queue-based trapezoidal reference model.
module tb_integration_sequencer;
    localparam int STEP = 5;

    logic clk = 1'b0;
    logic resetb;
    int   total = 0;
    int   bad   = 0;

    bit [63:0] samp_q[$];
    bit [63:0] exp_res64;
    bit [63:0] exp_res8;

    always #5 clk = ~clk;

    integration_sequencer_if #(.DW(64), .CW(16)) bus64 ();
    integration_sequencer_if #(.DW(8),  .CW(16)) bus8 ();

    integration_sequencer #(.DW(64), .CW(16), .STEP(STEP)) u_dut64 (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus64)
    );

    integration_sequencer #(.DW(8), .CW(16), .STEP(STEP)) u_dut8 (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Integral of a sample sequence: sum over adjacent pairs of STEP*(a+b), mod 2^dw.
    function automatic bit [63:0] ref_trap(input bit [63:0] q[$], input int dw);
        bit [63:0] mask;
        bit [63:0] acc;
        mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
        acc  = '0;
        for (int i = 1; i < q.size(); i++)
            acc = (acc + (((q[i-1] + q[i]) & mask) * 64'(STEP))) & mask;
        return acc;
    endfunction

    // One full window on the 64-bit instance using samp_q; gap<0 means random gaps 0..2.
    task automatic run64(input int n, input int gap, input bit start_in_done, input string tag);
        int g;
        bus64.num_samples = 16'(n);
        bus64.start       = 1'b1;
        tick();
        bus64.start       = 1'b0;
        check({tag, "_busy_rise"}, bus64.busy, 1);
        if (n < 2) begin
            exp_res64 = '0;
            check({tag, "_done_short"}, bus64.done, 1);
            check({tag, "_ready_short"}, bus64.sample_ready, 0);
            check({tag, "_result_short"}, bus64.result, 0);
        end else begin
            check({tag, "_ready_first"}, bus64.sample_ready, 1);
            for (int i = 0; i < n; i++) begin
                g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
                for (int k = 0; k < g; k++) begin
                    tick();
                    check({tag, "_ready_stall"}, bus64.sample_ready, 1);
                end
                check({tag, "_no_early_done"}, bus64.done, 0);
                bus64.sample_valid = 1'b1;
                bus64.sample_data  = samp_q[i];
                tick();
                bus64.sample_valid = 1'b0;
            end
            exp_res64 = ref_trap(samp_q, 64);
            check({tag, "_done"}, bus64.done, 1);
            check({tag, "_result"}, bus64.result, exp_res64);
        end
        if (start_in_done) begin
            bus64.start       = 1'b1;
            bus64.num_samples = 16'd0;
        end
        tick();
        bus64.start = 1'b0;
        check({tag, "_done_fall"}, bus64.done, 0);
        check({tag, "_busy_fall"}, bus64.busy, 0);
        check({tag, "_result_hold"}, bus64.result, exp_res64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus64.start = 1'b0; bus64.num_samples = '0; bus64.abort = 1'b0;
        bus64.sample_valid = 1'b0; bus64.sample_data = '0;
        bus8.start = 1'b0; bus8.num_samples = '0; bus8.abort = 1'b0;
        bus8.sample_valid = 1'b0; bus8.sample_data = '0;
        exp_res64 = '0;
        exp_res8  = '0;

        resetb = 1'b1;
        tick();
        tick();
        resetb = 1'b0;
        check("rst_ready", bus64.sample_ready, 0);
        check("rst_busy", bus64.busy, 0);
        check("rst_done", bus64.done, 0);
        check("rst_result", bus64.result, 0);
        check("rst_result8", bus8.result, 0);

        // n=4, 1..4 back to back; a start pulse in the DONE cycle must be ignored.
        samp_q = '{64'd1, 64'd2, 64'd3, 64'd4};
        run64(4, 0, 1'b1, "n4");
        check("n4_value75", bus64.result, 64'd75);

        // Abort after two samples, same cycle as a valid third; start while busy ignored.
        bus64.num_samples = 16'd4;
        bus64.start = 1'b1;
        tick();
        bus64.num_samples = 16'd2;
        bus64.sample_valid = 1'b1;
        bus64.sample_data = 64'd5;
        tick();
        bus64.start = 1'b0;
        bus64.sample_data = 64'd6;
        tick();
        check("abort_no_relatch", bus64.done, 0);
        bus64.sample_data = 64'd7;
        bus64.abort = 1'b1;
        tick();
        bus64.abort = 1'b0;
        bus64.sample_valid = 1'b0;
        check("abort_busy", bus64.busy, 0);
        check("abort_ready", bus64.sample_ready, 0);
        check("abort_done", bus64.done, 0);
        check("abort_result", bus64.result, exp_res64);
        tick();
        check("abort_done_later", bus64.done, 0);
        check("abort_result_later", bus64.result, 64'd75);

        // n=2 with 3-cycle valid gaps.
        samp_q = '{64'd10, 64'd20};
        run64(2, 3, 1'b0, "gap");
        check("gap_value150", bus64.result, 64'd150);

        samp_q.delete();
        run64(1, 0, 1'b0, "n1");
        samp_q = '{64'd9, 64'd9};
        run64(2, 0, 1'b0, "pre_n0");
        samp_q.delete();
        run64(0, 0, 1'b0, "n0");

        // 8-bit instance: 100,100 wraps 1000 to 232.
        bus8.num_samples = 16'd2;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.sample_valid = 1'b1;
        bus8.sample_data = 8'd100;
        tick();
        tick();
        bus8.sample_valid = 1'b0;
        samp_q = '{64'd100, 64'd100};
        exp_res8 = ref_trap(samp_q, 8);
        check("dw8_done", bus8.done, 1);
        check("dw8_result", bus8.result, exp_res8);
        check("dw8_value232", bus8.result, 64'd232);
        tick();
        check("dw8_busy_fall", bus8.busy, 0);

        // Random 8-bit window exercising wrap of pair sums and products.
        samp_q.delete();
        for (int i = 0; i < 5; i++) samp_q.push_back(64'($urandom_range(255, 0)));
        bus8.num_samples = 16'd5;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("dw8r_no_early_done", bus8.done, 0);
            bus8.sample_valid = 1'b1;
            bus8.sample_data = samp_q[i][7:0];
            tick();
        end
        bus8.sample_valid = 1'b0;
        exp_res8 = ref_trap(samp_q, 8);
        check("dw8r_done", bus8.done, 1);
        check("dw8r_result", bus8.result, exp_res8);
        tick();

        // Randomized 64-bit windows with random gaps.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(7, 0));
            samp_q.delete();
            for (int i = 0; i < n; i++) samp_q.push_back({$urandom, $urandom});
            run64(n, -1, 1'b0, "rnd");
        end

        // Reset asserted in ACCUM: everything back to reset values, no done.
        bus64.num_samples = 16'd4;
        bus64.start = 1'b1;
        tick();
        bus64.start = 1'b0;
        bus64.sample_valid = 1'b1;
        bus64.sample_data = 64'd3;
        tick();
        tick();
        resetb = 1'b1;
        tick();
        resetb = 1'b0;
        bus64.sample_valid = 1'b0;
        check("midrst_ready", bus64.sample_ready, 0);
        check("midrst_busy", bus64.busy, 0);
        check("midrst_done", bus64.done, 0);
        check("midrst_result", bus64.result, 0);
        exp_res64 = '0;
        tick();
        check("midrst_idle_done", bus64.done, 0);
        samp_q = '{64'd1, 64'd1};
        run64(2, 0, 1'b0, "post_rst");
        check("post_rst_value10", bus64.result, 64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
